// File: rtl/estagio_busca.sv
// nRISC instruction-fetch stage: PC, instruction-memory handshake and FETCH/ISSUE/HALTED sequencing.
// Define FETCH_INSTR_COUNT_EN to build the saturating retired-instruction counter on instr_count.
module estagio_busca #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_rd,
    input  logic [7:0]          imem_data,
    input  logic                imem_valid,
    output logic [7:0]          Instr,
    output logic [2:0]          Opcode,
    output logic                Funct,
    output logic                instr_valid,
    input  logic                stall,
    input  logic                Branch,
    input  logic                Zero,
    input  logic                Jump,
    input  logic                Halt,
    input  logic [PC_WIDTH-1:0] Target,
    output logic                halted,
    output logic [15:0]         instr_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [7:0]          r_instr;
    logic                w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_instr <= 8'h00;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_accept)
                r_instr <= imem_data;
        end
    end

    // Control inputs only matter on the retire cycle (ISSUE, not stalled); Halt leaves PC on the HALT word.
    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_accept  = 1'b0;
        case (r_state)
            FETCH: begin
                if (imem_valid) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (Halt) begin
                        w_next = HALTED;
                    end else begin
                        w_next = FETCH;
                        if (Jump || (Branch && Zero))
                            w_pc_next = Target;
                        else
                            w_pc_next = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
            HALTED: begin
                w_next = HALTED;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    assign imem_rd     = (r_state == FETCH) && !reset;
    assign imem_addr   = r_pc;
    assign Instr       = r_instr;
    assign Opcode      = r_instr[7:5];
    assign Funct       = r_instr[0];
    assign instr_valid = (r_state == ISSUE);
    assign halted      = (r_state == HALTED);

`ifdef FETCH_INSTR_COUNT_EN
    logic        w_retire;
    logic [15:0] r_count;

    assign w_retire = (r_state == ISSUE) && !stall;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= 16'h0000;
        else if (w_retire && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;
    end

    assign instr_count = r_count;
`else
    assign instr_count = 16'h0000;
`endif

endmodule
